// File: rtl/dec_ser_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dec_ser_pkg
// Purpose  : Shared constants, FSM state type and frame-length helper for
//            dec_serializer. Frame length grows by one when DEC_SER_PARITY_EN
//            is defined.
// Revision : 1.0 - initial release
// ============================================================================
package dec_ser_pkg;

    localparam int c_DEF_DATA_W     = 8;
    localparam int c_DEF_FIFO_DEPTH = 4;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    function automatic int frame_len(input int data_w);
`ifdef DEC_SER_PARITY_EN
        return data_w + 1;
`else
        return data_w;
`endif
    endfunction

endpackage
`default_nettype wire

// File: rtl/dec_ser_fifo.sv
`default_nettype none
// ============================================================================
// Module   : dec_ser_fifo
// Purpose  : Synchronous FIFO with push/pop, full/empty flags and occupancy.
// Revision : 1.0 - initial release
// ============================================================================
module dec_ser_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset so it can map onto plain register files.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= wdata;
    end

    assign rdata = r_mem[r_rd_ptr];
    assign full  = (r_count == c_CNT_W'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/dec_serializer.sv
`default_nettype none
// ============================================================================
// Module   : dec_serializer
// Purpose  : Buffers decoded words and shifts them out LSB-first with
//            first/last frame markers. Define DEC_SER_PARITY_EN to append an
//            even-parity bit to every frame.
// Revision : 1.0 - initial release
// ============================================================================
module dec_serializer
    import dec_ser_pkg::*;
#(
    parameter int DATA_W     = c_DEF_DATA_W,
    parameter int FIFO_DEPTH = c_DEF_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data_in,
    input  logic              ser_ready,
    output logic              ser_valid,
    output logic              ser_out,
    output logic              ser_first,
    output logic              ser_last
);

    localparam int c_FRAME_LEN = frame_len(DATA_W);
    localparam int c_CNT_W     = $clog2(c_FRAME_LEN + 1);
    localparam int c_FCNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_CNT_W-1:0]  c_LAST_BIT  = c_CNT_W'(c_FRAME_LEN - 1);
    localparam logic [c_FCNT_W-1:0] c_FIFO_FULL = c_FCNT_W'(FIFO_DEPTH);

    state_t                   r_state,     w_state_nxt;
    logic [c_FRAME_LEN-1:0]   r_shift,     w_shift_nxt;
    logic [c_CNT_W-1:0]       r_bit_cnt,   w_bit_cnt_nxt;
    logic                     r_ser_valid, w_ser_valid_nxt;
    logic                     r_ser_first, w_ser_first_nxt;
    logic                     r_ser_last,  w_ser_last_nxt;
    logic                     r_in_ready;

    logic [DATA_W-1:0]        w_fifo_data;
    logic [c_FRAME_LEN-1:0]   w_frame;
    logic [c_FCNT_W-1:0]      w_count;
    logic [c_FCNT_W-1:0]      w_count_nxt;
    logic [c_CNT_W-1:0]       w_cnt_inc;
    logic                     w_full;
    logic                     w_empty;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_accept;

`ifdef DEC_SER_PARITY_EN
    assign w_frame = {^w_fifo_data, w_fifo_data};
`else
    assign w_frame = w_fifo_data;
`endif

    assign w_push    = in_valid && r_in_ready && !w_full;
    assign w_accept  = r_ser_valid && ser_ready;
    assign w_cnt_inc = r_bit_cnt + c_CNT_W'(1);

    dec_ser_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (data_in),
        .rdata (w_fifo_data),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    // in_ready tracks the occupancy the FIFO will have after this edge.
    assign w_count_nxt = w_count + c_FCNT_W'(w_push) - c_FCNT_W'(w_pop);

    always_comb begin
        w_state_nxt     = r_state;
        w_shift_nxt     = r_shift;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_ser_valid_nxt = r_ser_valid;
        w_ser_first_nxt = r_ser_first;
        w_ser_last_nxt  = r_ser_last;
        w_pop           = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop           = 1'b1;
                    w_state_nxt     = ST_SHIFT;
                    w_shift_nxt     = w_frame;
                    w_bit_cnt_nxt   = '0;
                    w_ser_valid_nxt = 1'b1;
                    w_ser_first_nxt = 1'b1;
                    w_ser_last_nxt  = (c_FRAME_LEN == 1);
                end
            end
            ST_SHIFT: begin
                if (w_accept) begin
                    if (r_bit_cnt == c_LAST_BIT) begin
                        if (!w_empty) begin
                            // Reload on the closing edge so frames run back-to-back.
                            w_pop           = 1'b1;
                            w_shift_nxt     = w_frame;
                            w_bit_cnt_nxt   = '0;
                            w_ser_first_nxt = 1'b1;
                            w_ser_last_nxt  = (c_FRAME_LEN == 1);
                        end else begin
                            w_state_nxt     = ST_IDLE;
                            w_shift_nxt     = '0;
                            w_bit_cnt_nxt   = '0;
                            w_ser_valid_nxt = 1'b0;
                            w_ser_first_nxt = 1'b0;
                            w_ser_last_nxt  = 1'b0;
                        end
                    end else begin
                        w_shift_nxt     = r_shift >> 1;
                        w_bit_cnt_nxt   = w_cnt_inc;
                        w_ser_first_nxt = 1'b0;
                        w_ser_last_nxt  = (w_cnt_inc == c_LAST_BIT);
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_ser_valid <= 1'b0;
            r_ser_first <= 1'b0;
            r_ser_last  <= 1'b0;
            r_in_ready  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shift     <= w_shift_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_ser_valid <= w_ser_valid_nxt;
            r_ser_first <= w_ser_first_nxt;
            r_ser_last  <= w_ser_last_nxt;
            r_in_ready  <= (w_count_nxt != c_FIFO_FULL);
        end
    end

    assign in_ready  = r_in_ready;
    assign ser_valid = r_ser_valid;
    assign ser_out   = r_shift[0];
    assign ser_first = r_ser_first;
    assign ser_last  = r_ser_last;

endmodule
`default_nettype wire

// File: tb/tb_dec_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dec_serializer
// Purpose  : Directed and random self-checking bench for dec_serializer
//            against a bit-queue reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dec_serializer;

    localparam int W     = 8;
    localparam int DEPTH = 4;
`ifdef DEC_SER_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    typedef struct {
        bit b;
        bit f;
        bit l;
    } ebit_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         ser_ready = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         in_ready;
    logic         ser_valid;
    logic         ser_out;
    logic         ser_first;
    logic         ser_last;

    ebit_t exp_q[$];
    bit    got[$];
    bit    gotf[$];
    int    held = 0;
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    vcnt = 0;
    int    vfirst = -1;
    int    vlast = -1;
    int    nacc;
    int    nfirst;
    bit    push_now;
    bit    bit_now;
    bit    smp_out;
    bit    smp_first;
    logic [8:0] exp9;

    dec_serializer #(
        .DATA_W     (W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .ser_ready (ser_ready),
        .ser_valid (ser_valid),
        .ser_out   (ser_out),
        .ser_first (ser_first),
        .ser_last  (ser_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs at the falling edge, then update the model
    // with the handshakes that the following rising edge completes.
    task automatic cycle();
        @(negedge clk);
        push_now  = (in_valid === 1'b1) && (in_ready === 1'b1);
        bit_now   = (ser_valid === 1'b1) && (ser_ready === 1'b1);
        smp_out   = ser_out;
        smp_first = ser_first;
        chk("in_ready", in_ready, (held <= DEPTH));
        if (ser_valid !== 1'b0) begin
            vcnt++;
            if (vfirst < 0) vfirst = cyc;
            vlast = cyc;
            if (exp_q.size() == 0) begin
                chk("extra_bit", ser_valid, 0);
            end else begin
                chk("ser_out", ser_out, exp_q[0].b);
                chk("ser_first", ser_first, exp_q[0].f);
                chk("ser_last", ser_last, exp_q[0].l);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (push_now) begin
            for (int i = 0; i < W; i++)
                exp_q.push_back('{b: data_in[i], f: (i == 0), l: (i == FL - 1)});
            if (FL > W) exp_q.push_back('{b: ^data_in, f: 1'b0, l: 1'b1});
            held++;
        end
        if (bit_now && exp_q.size() > 0) begin
            if (exp_q[0].l) held--;
            got.push_back(smp_out);
            gotf.push_back(smp_first);
            void'(exp_q.pop_front());
        end
    endtask

    task automatic clear_log();
        got.delete();
        gotf.delete();
        vcnt   = 0;
        vfirst = -1;
        vlast  = -1;
    endtask

    task automatic apply_reset();
        rst       = 1'b0;
        in_valid  = 1'b0;
        ser_ready = 1'b0;
        #1;
        chk("rst_valid", ser_valid, 0);
        chk("rst_out", ser_out, 0);
        chk("rst_first", ser_first, 0);
        chk("rst_last", ser_last, 0);
        chk("rst_in_ready", in_ready, 0);
        exp_q.delete();
        held = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        chk("rel_in_ready_low", in_ready, 0);
        @(posedge clk);
        #1;
        chk("rel_in_ready_rise", in_ready, 1);
    endtask

    task automatic drain(input int bound);
        for (int i = 0; i < bound && held > 0; i++) cycle();
        chk("drain_timeout", held, 0);
        cycle();
        chk("drain_idle", ser_valid, 0);
    endtask

    function automatic logic [W-1:0] word_at(input int k);
        logic [W-1:0] r;
        r = 'x;
        if (got.size() >= (k + 1) * FL)
            for (int i = 0; i < W; i++) r[i] = got[k * FL + i];
        return r;
    endfunction

    initial begin
        #2;
        apply_reset();

        // Single word, no backpressure
        clear_log();
        ser_ready = 1'b1;
        in_valid  = 1'b1;
        data_in   = 8'hA5;
        cycle();
        in_valid = 1'b0;
        chk("a5_not_yet_valid", ser_valid, 0);
        cycle();
        chk("a5_valid", ser_valid, 1);
        chk("a5_first", ser_first, 1);
        chk("a5_bit0", ser_out, 1);
        drain(40);
        chk("a5_word", word_at(0), 8'hA5);
        chk("a5_nbits", got.size(), FL);

        // Back-to-back frames
        clear_log();
        in_valid = 1'b1;
        data_in  = 8'h3C;
        cycle();
        data_in = 8'hC3;
        cycle();
        in_valid = 1'b0;
        drain(60);
        chk("b2b_word0", word_at(0), 8'h3C);
        chk("b2b_word1", word_at(1), 8'hC3);
        chk("b2b_valid_cycles", vcnt, 2 * FL);
        chk("b2b_contiguous", vlast - vfirst + 1, 2 * FL);
        nfirst = 0;
        foreach (gotf[i]) if (gotf[i]) nfirst++;
        chk("b2b_first_count", nfirst, 2);
        chk("b2b_first_second", gotf.size() > FL ? gotf[FL] : 1'b0, 1);

        // Backpressure at bit 3
        clear_log();
        in_valid = 1'b1;
        data_in  = 8'hF0;
        cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 20 && !(ser_valid === 1'b1 && got.size() == 3); i++) cycle();
        ser_ready = 1'b0;
        repeat (3) begin
            cycle();
            chk("bp_valid_held", ser_valid, 1);
            chk("bp_out_held", ser_out, 0);
            chk("bp_last_held", ser_last, 0);
        end
        chk("bp_nbits_held", got.size(), 3);
        ser_ready = 1'b1;
        drain(40);
        chk("bp_bit4", got.size() > 4 ? got[4] : 1'b0, 1);
        chk("bp_word", word_at(0), 8'hF0);
        chk("bp_nbits", got.size(), FL);

        // Fill to capacity with the output stalled
        clear_log();
        ser_ready = 1'b0;
        in_valid  = 1'b1;
        data_in   = 8'h01;
        nacc      = 0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (push_now) begin
                nacc++;
                data_in = data_in + 8'd1;
            end
        end
        chk("full_accepted", nacc, DEPTH + 1);
        chk("full_in_ready", in_ready, 0);
        ser_ready = 1'b1;
        for (int i = 0; i < 100 && in_valid; i++) begin
            cycle();
            if (push_now) begin
                nacc++;
                in_valid = 1'b0;
            end
        end
        chk("full_sixth_accepted", nacc, 6);
        drain(200);
        for (int k = 0; k < 6; k++) chk("full_order", word_at(k), k + 1);

        // Reset mid-frame with words queued
        clear_log();
        ser_ready = 1'b1;
        in_valid  = 1'b1;
        data_in   = 8'h5A;
        cycle();
        data_in = 8'h11;
        cycle();
        data_in = 8'h22;
        cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 20 && !(ser_valid === 1'b1 && got.size() == 4); i++) cycle();
        chk("rm_mid_frame", got.size(), 4);
        apply_reset();
        clear_log();
        ser_ready = 1'b1;
        repeat (6) cycle();
        chk("rm_no_stale", vcnt, 0);

`ifdef DEC_SER_PARITY_EN
        clear_log();
        in_valid = 1'b1;
        data_in  = 8'h07;
        cycle();
        in_valid = 1'b0;
        drain(40);
        exp9 = 9'b1_0000_0111;
        for (int i = 0; i < 9; i++) chk("par07_bit", got.size() > i ? got[i] : 1'bx, exp9[i]);
        clear_log();
        in_valid = 1'b1;
        data_in  = 8'h03;
        cycle();
        in_valid = 1'b0;
        drain(40);
        chk("par03_parity", got.size() > 8 ? got[8] : 1'bx, 0);
`endif

        // Random traffic against the model
        clear_log();
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 99) < 60);
            data_in   = W'($urandom);
            ser_ready = ($urandom_range(0, 99) < 70);
            cycle();
        end
        in_valid  = 1'b0;
        ser_ready = 1'b1;
        drain(300);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
